// File: rtl/pipe_hazard_ctrl.sv
// ID-stage hazard and forwarding controller for a 5-stage pipeline.
// Tracks EX/MEM destination history and derives operand selects, stalls and a stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            IDvalid,
  input  logic [4:0]      IDrs,
  input  logic [4:0]      IDrt,
  input  logic            IDuseRs,
  input  logic            IDuseRt,
  input  logic            IDshift,
  input  logic            IDimme,
  input  logic            IDwreg,
  input  logic            IDm2reg,
  input  logic            IDwmem,
  input  logic [4:0]      IDwn,
  output logic [1:0]      selectAlua,
  output logic [1:0]      selectAlub,
  output logic            isStoreHazards,
  output logic            stall,
  output logic            bubble,
  output logic [CNTW-1:0] stallCount
);

  localparam logic [1:0] SelReg  = 2'd0;
  localparam logic [1:0] SelImm  = 2'd1;
  localparam logic [1:0] SelMem  = 2'd2;
  localparam logic [1:0] SelWb   = 2'd3;

  logic            r_ex_wreg;
  logic            r_ex_m2reg;
  logic [4:0]      r_ex_wn;
  logic            r_mem_wreg;
  logic [4:0]      r_mem_wn;
  logic [CNTW-1:0] r_stall_cnt;

  logic w_ex_live;
  logic w_mem_live;
  logic w_hit_ex_rs;
  logic w_hit_ex_rt;
  logic w_hit_mem_rs;
  logic w_hit_mem_rt;
  logic w_load_use;
  logic w_store_mem;
  logic w_stall;
  logic w_cnt_sat;

  // $0 is hard-wired zero, so a producer writing it never matches.
  assign w_ex_live  = r_ex_wreg & (r_ex_wn != 5'd0);
  assign w_mem_live = r_mem_wreg & (r_mem_wn != 5'd0);

  assign w_hit_ex_rs  = w_ex_live & (r_ex_wn == IDrs);
  assign w_hit_ex_rt  = w_ex_live & (r_ex_wn == IDrt);
  assign w_hit_mem_rs = w_mem_live & (r_mem_wn == IDrs);
  assign w_hit_mem_rt = w_mem_live & (r_mem_wn == IDrt);

  assign w_load_use = r_ex_m2reg &
                      ((IDuseRs & ~IDshift & w_hit_ex_rs) | (IDuseRt & w_hit_ex_rt));

  // Store data is latched in ID; a MEM-stage producer would leave it stale.
  assign w_store_mem = IDwmem & IDuseRt & w_hit_mem_rt & ~w_hit_ex_rt;

  assign w_stall   = IDvalid & (w_load_use | w_store_mem);
  assign w_cnt_sat = &r_stall_cnt;

  always_comb begin
    selectAlua = SelReg;
    if (IDshift) begin
      selectAlua = SelImm;
    end else if (IDuseRs && w_hit_ex_rs) begin
      selectAlua = SelMem;
    end else if (IDuseRs && w_hit_mem_rs) begin
      selectAlua = SelWb;
    end
  end

  always_comb begin
    selectAlub = SelReg;
    if (IDimme) begin
      selectAlub = SelImm;
    end else if (IDwmem) begin
      selectAlub = SelReg;
    end else if (IDuseRt && w_hit_ex_rt) begin
      selectAlub = SelMem;
    end else if (IDuseRt && w_hit_mem_rt) begin
      selectAlub = SelWb;
    end
  end

  assign isStoreHazards = IDvalid & IDwmem & IDuseRt & w_hit_ex_rt & ~r_ex_m2reg & ~w_stall;
  assign stall          = w_stall;
  assign bubble         = w_stall;
  assign stallCount     = r_stall_cnt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ex_wreg   <= 1'b0;
      r_ex_m2reg  <= 1'b0;
      r_ex_wn     <= 5'd0;
      r_mem_wreg  <= 1'b0;
      r_mem_wn    <= 5'd0;
      r_stall_cnt <= '0;
    end else begin
      r_mem_wreg <= r_ex_wreg;
      r_mem_wn   <= r_ex_wn;
      if (w_stall || !IDvalid) begin
        r_ex_wreg  <= 1'b0;
        r_ex_m2reg <= 1'b0;
        r_ex_wn    <= 5'd0;
      end else begin
        r_ex_wreg  <= IDwreg;
        r_ex_m2reg <= IDm2reg;
        r_ex_wn    <= IDwn;
      end
      if (w_stall && !w_cnt_sat) begin
        r_stall_cnt <= r_stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: instruction sequences checked against a producer-search
// model every cycle, plus hand-computed expectations at the interesting points.
module tb_pipe_hazard_ctrl;

  localparam int CNTW    = 3;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  localparam bit [4:0] MA   = 5'b00001;
  localparam bit [4:0] MB   = 5'b00010;
  localparam bit [4:0] MISH = 5'b00100;
  localparam bit [4:0] MST  = 5'b01000;
  localparam bit [4:0] MCNT = 5'b10000;

  logic            clk;
  logic            clrn;
  logic            IDvalid;
  logic [4:0]      IDrs;
  logic [4:0]      IDrt;
  logic            IDuseRs;
  logic            IDuseRt;
  logic            IDshift;
  logic            IDimme;
  logic            IDwreg;
  logic            IDm2reg;
  logic            IDwmem;
  logic [4:0]      IDwn;
  logic [1:0]      selectAlua;
  logic [1:0]      selectAlub;
  logic            isStoreHazards;
  logic            stall;
  logic            bubble;
  logic [CNTW-1:0] stallCount;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.CNTW(CNTW)) dut (
    .clk            (clk),
    .clrn           (clrn),
    .IDvalid        (IDvalid),
    .IDrs           (IDrs),
    .IDrt           (IDrt),
    .IDuseRs        (IDuseRs),
    .IDuseRt        (IDuseRt),
    .IDshift        (IDshift),
    .IDimme         (IDimme),
    .IDwreg         (IDwreg),
    .IDm2reg        (IDm2reg),
    .IDwmem         (IDwmem),
    .IDwn           (IDwn),
    .selectAlua     (selectAlua),
    .selectAlub     (selectAlub),
    .isStoreHazards (isStoreHazards),
    .stall          (stall),
    .bubble         (bubble),
    .stallCount     (stallCount)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Model: in-flight producers, index 0 = newest (EX), 1 = MEM.
  bit       h_wr [2];
  bit       h_ld [2];
  bit [4:0] h_wn [2];
  int       m_cnt;

  function automatic int m_src(input logic [4:0] r);
    if (r == 5'd0) return -1;
    for (int i = 0; i < 2; i++) begin
      if (h_wr[i] && h_wn[i] == r) return i;
    end
    return -1;
  endfunction

  function automatic int m_sel_a();
    if (IDshift) return 1;
    if (IDuseRs && m_src(IDrs) >= 0) return 2 + m_src(IDrs);
    return 0;
  endfunction

  function automatic int m_sel_b();
    if (IDimme) return 1;
    if (IDwmem) return 0;
    if (IDuseRt && m_src(IDrt) >= 0) return 2 + m_src(IDrt);
    return 0;
  endfunction

  function automatic bit m_stall();
    bit lu;
    bit sm;
    lu = h_ld[0] && ((IDuseRs && !IDshift && m_src(IDrs) == 0) ||
                     (IDuseRt && m_src(IDrt) == 0));
    sm = IDwmem && IDuseRt && m_src(IDrt) == 1;
    return IDvalid && (lu || sm);
  endfunction

  function automatic bit m_ish();
    return IDvalid && IDwmem && IDuseRt && m_src(IDrt) == 0 && !h_ld[0] && !m_stall();
  endfunction

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < 2; i++) begin
        h_wr[i] <= 1'b0;
        h_ld[i] <= 1'b0;
        h_wn[i] <= 5'd0;
      end
      m_cnt <= 0;
    end else begin
      h_wr[1] <= h_wr[0];
      h_ld[1] <= h_ld[0];
      h_wn[1] <= h_wn[0];
      if (m_stall() || !IDvalid) begin
        h_wr[0] <= 1'b0;
        h_ld[0] <= 1'b0;
        h_wn[0] <= 5'd0;
      end else begin
        h_wr[0] <= IDwreg;
        h_ld[0] <= IDm2reg;
        h_wn[0] <= IDwn;
      end
      if (m_stall() && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
    end
  end

  // Literal expectations posted by the stimulus and checked by the compare process.
  bit       lit_en  = 1'b0;
  bit [4:0] lit_m;
  string    lit_tag;
  int       lit_a, lit_b, lit_ish, lit_st, lit_cnt;
  bit       chk_tgl = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk or chk_tgl) begin
    chk("selectAlua", int'(selectAlua), m_sel_a());
    chk("selectAlub", int'(selectAlub), m_sel_b());
    chk("isStoreHazards", int'(isStoreHazards), int'(m_ish()));
    chk("stall", int'(stall), int'(m_stall()));
    chk("bubble", int'(bubble), int'(m_stall()));
    chk("stallCount", int'(stallCount), m_cnt);
    if (lit_en) begin
      if (lit_m[0]) chk({lit_tag, ".selA"}, int'(selectAlua), lit_a);
      if (lit_m[1]) chk({lit_tag, ".selB"}, int'(selectAlub), lit_b);
      if (lit_m[2]) chk({lit_tag, ".ish"}, int'(isStoreHazards), lit_ish);
      if (lit_m[3]) chk({lit_tag, ".stall"}, int'(stall), lit_st);
      if (lit_m[4]) chk({lit_tag, ".cnt"}, int'(stallCount), lit_cnt);
    end
  end

  task automatic post(input string tag, input bit [4:0] m,
                      input int a, input int b, input int ish, input int st, input int cnt);
    lit_tag = tag;
    lit_m   = m;
    lit_a   = a;
    lit_b   = b;
    lit_ish = ish;
    lit_st  = st;
    lit_cnt = cnt;
    lit_en  = 1'b1;
  endtask

  task automatic lit(input string tag, input bit [4:0] m,
                     input int a, input int b, input int ish, input int st, input int cnt);
    post(tag, m, a, b, ish, st, cnt);
    @(negedge clk);
    #1 lit_en = 1'b0;
  endtask

  task automatic lit_now(input string tag, input bit [4:0] m,
                         input int a, input int b, input int ish, input int st, input int cnt);
    post(tag, m, a, b, ish, st, cnt);
    chk_tgl = ~chk_tgl;
    #1 lit_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit [4:0] rs, input bit [4:0] rt,
                       input bit urs, input bit urt, input bit sh, input bit im,
                       input bit wr, input bit ld, input bit wm, input bit [4:0] wn);
    IDvalid = v;   IDrs = rs;     IDrt = rt;
    IDuseRs = urs; IDuseRt = urt; IDshift = sh; IDimme = im;
    IDwreg = wr;   IDm2reg = ld;  IDwmem = wm;  IDwn = wn;
  endtask

  task automatic i_add(input bit [4:0] rd, input bit [4:0] rs, input bit [4:0] rt);
    drive(1, rs, rt, 1, 1, 0, 0, 1, 0, 0, rd);
  endtask
  task automatic i_lw(input bit [4:0] rt, input bit [4:0] rs);
    drive(1, rs, rt, 1, 0, 0, 1, 1, 1, 0, rt);
  endtask
  task automatic i_sw(input bit [4:0] rt, input bit [4:0] rs);
    drive(1, rs, rt, 1, 1, 0, 1, 0, 0, 1, 5'd0);
  endtask
  task automatic i_addi(input bit [4:0] rt, input bit [4:0] rs);
    drive(1, rs, rt, 1, 0, 0, 1, 1, 0, 0, rt);
  endtask
  task automatic i_sll(input bit [4:0] rd, input bit [4:0] rt);
    drive(1, 5'd0, rt, 0, 1, 1, 0, 1, 0, 0, rd);
  endtask
  task automatic i_nop();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    clrn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lit("reset", MA | MB | MISH | MST | MCNT, 0, 0, 0, 0, 0);
    #2 clrn = 1'b1;
    step();

    // Back-to-back and one-gap ALU forwarding.
    i_add(3, 1, 2);    step();
    i_add(4, 3, 3);    lit("fwd_ex", MA | MB | MST, 2, 2, 0, 0, 0);     step();
    i_add(3, 1, 2);    step();
    i_nop();           step();
    i_add(4, 3, 3);    lit("fwd_mem", MA | MB | MST, 3, 3, 0, 0, 0);    step();

    // Newest producer wins.
    i_add(5, 1, 2);    step();
    i_add(5, 2, 1);    step();
    i_add(6, 5, 5);    lit("priority", MA | MB | MST, 2, 2, 0, 0, 0);   step();

    // Load-use: one stall cycle, then WB forward.
    i_lw(7, 1);        step();
    i_add(8, 7, 2);    lit("lu_stall", MA | MB | MST | MCNT, 2, 0, 0, 1, 0); step();
    lit("lu_release", MA | MB | MST | MCNT, 3, 0, 0, 0, 1);                 step();

    // Store after ALU producer, then store after load (two stall cycles).
    i_add(9, 1, 2);    step();
    i_sw(9, 1);        lit("st_alu", MA | MB | MISH | MST, 0, 1, 1, 0, 0);  step();
    i_lw(9, 1);        step();
    i_sw(9, 1);        lit("st_ld1", MB | MISH | MST | MCNT, 0, 1, 0, 1, 1); step();
    lit("st_ld2", MISH | MST | MCNT, 0, 0, 0, 1, 2);                         step();
    lit("st_ld3", MA | MISH | MST | MCNT, 0, 0, 0, 0, 3);                    step();

    // $0 never matches; immediates and shifts select 1.
    i_add(0, 1, 2);    step();
    i_addi(2, 0);      lit("reg0", MA | MB | MST, 0, 1, 0, 0, 0);       step();
    i_add(3, 1, 2);    step();
    i_sll(3, 3);       lit("shift", MA | MB | MST, 1, 2, 0, 0, 0);      step();

    // Empty ID slot: selects still computed, no stall.
    i_lw(7, 1);        step();
    drive(0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    lit("invalid", MA | MISH | MST, 2, 0, 0, 0, 0);                       step();

    // Counter saturation: five more stalls from 3 pin at CNT_MAX.
    for (int k = 0; k < 5; k++) begin
      i_lw(7, 1);      step();
      i_add(8, 7, 2);  step();
      step();
    end
    i_nop();           lit("saturate", MST | MCNT, 0, 0, 0, 0, CNT_MAX); step();

    // Asynchronous reset in the middle of a stall.
    i_lw(7, 1);        step();
    i_add(8, 7, 2);
    #1 lit_now("pre_reset", MA | MST, 2, 0, 0, 1, 0);
    #1 clrn = 1'b0;
    #1 lit_now("async_reset", MA | MB | MISH | MST | MCNT, 0, 0, 0, 0, 0);
    #3 clrn = 1'b1;
    i_nop();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- ID-stage hazard and forwarding controller for the 5-stage pipeline.
- Keeps its own shadow history of the destination registers of the instructions now in EX and MEM.
- From that history, for the instruction in ID it produces:
  - ALU operand-mux selects (selectAlua/selectAlub) that are registered into ID/EX;
  - the store-data hazard flag;
  - load-use / store-data stall and bubble controls.
- Also counts stall cycles for performance monitoring.

Parameters:
- CNTW, 16, width of saturating stall-cycle counter

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- clrn  in  1  asynchronous active-low reset
- IDvalid  in  1  ID holds a real instruction (0 = empty/flushed slot)
- IDrs  in  5  rs field of ID instruction
- IDrt  in  5  rt field of ID instruction
- IDuseRs  in  1  instruction reads rs as ALU operand A
- IDuseRt  in  1  instruction reads rt (ALU operand B or store data)
- IDshift  in  1  operand A is shift amount (sa), not rs
- IDimme  in  1  operand B is immediate, not rt
- IDwreg  in  1  instruction writes register file
- IDm2reg  in  1  instruction is a load
- IDwmem  in  1  instruction is a store (rt is store data, not ALU operand)
- IDwn  in  5  destination register number
- selectAlua  out  2  operand-A mux select: 0 qa, 1 saOrImme, 2 MEMaluResult, 3 WBdata
- selectAlub  out  2  operand-B mux select, same encoding
- isStoreHazards  out  1  store data must be replaced by WBdata in MEM
- stall  out  1  freeze PC and IF/ID register this cycle
- bubble  out  1  force wreg/wmem/m2reg to 0 into ID/EX this cycle
- stallCount  out  CNTW  saturating count of stall cycles

Behaviour:
- Register file is write-first: a producer in WB is read correctly in ID, so only EX and MEM producers are tracked.
- History registers:
  - exWreg, exM2reg, exWn = instruction entering EX on the last edge;
  - memWreg, memWn = instruction in MEM.
- Each rising clk:
  - memWreg <= exWreg; memWn <= exWn;
  - if bubble or !IDvalid: exWreg <= 0, exM2reg <= 0, exWn <= 0;
  - otherwise exWreg <= IDwreg, exM2reg <= IDm2reg, exWn <= IDwn.
- Reset (clrn=0, asynchronous, any time including mid-stall): all history 0, stallCount 0. Outputs therefore go to selects 0, stall 0, bubble 0, isStoreHazards 0.
- Match definitions (combinational):
  - hitEX(r) = exWreg & exWn!=0 & exWn==r;
  - hitMEM(r) = memWreg & memWn!=0 & memWn==r. Register $0 never matches.
- selectAlua:
  - IDshift → 1;
  - else IDuseRs & hitEX(rs) → 2;
  - else IDuseRs & hitMEM(rs) → 3;
  - else 0.
  - EX has priority over MEM (newest producer wins).
- selectAlub:
  - IDimme → 1;
  - else IDwmem → 0 (store data is never ALU-forwarded);
  - else IDuseRt & hitEX(rt) → 2;
  - else IDuseRt & hitMEM(rt) → 3;
  - else 0.
- isStoreHazards = IDvalid & IDwmem & IDuseRt & hitEX(rt) & !exM2reg & !stall.
- loadUse = exM2reg & ((IDuseRs & !IDshift & hitEX(rs)) | (IDuseRt & hitEX(rt))).
- storeMem = IDwmem & IDuseRt & hitMEM(rt) & !hitEX(rt). The producer is in MEM, and store data latched in ID would be stale.
- stall = bubble = IDvalid & (loadUse | storeMem). Outputs are combinational from current inputs and history; no extra latency.
- Stall cycle:
  - ID instruction is held;
  - bubble enters EX (history shifts in zeros);
  - next cycle the load is in MEM and the same instruction re-evaluates, selecting 3 for a load producer.
  - Store after load to the same rt stalls 2 cycles: loadUse, then storeMem.
- Selects are don't-care-free: they are always driven per the rules above, even while stall=1. ID/EX captures only a bubble then.
- stallCount increments on each rising edge with stall=1 and saturates at all-ones.
- IDvalid=0: stall/bubble/isStoreHazards 0; selects still computed.

Test Plan:
- Reset: clrn=0 mid-stall → stall=0, bubble=0, stallCount=0, selects 0/0 immediately, without a clock edge.
- ALU forward: `add $3,$1,$2` then `sub $4,$3,$3` → second instruction selectAlua=2, selectAlub=2, no stall. One-gap version (nop between) → 3/3.
- Priority: `add $5..`; `or $5..`; `and $6,$5,$5` → selects 2 (EX producer), not 3.
- Load-use: `lw $7,0($1)`; `add $8,$7,$2` → one cycle stall=bubble=1, then selectAlua=3, stall=0; stallCount=1.
- Store: `add $9..`; `sw $9,4($1)` → isStoreHazards=1, selectAlub=1, no stall. `lw $9`; `sw $9` → 2 stall cycles, isStoreHazards=0; stallCount=2.
- $0 and immediates: `add $0..`; `addi $2,$0,5` → selectAlua=0, selectAlub=1, no stall. Shift `sll $3,$3,2` after `add $3` → selectAlua=1, selectAlub=2.
